// File: rtl/cv32e40p_fetch_fifo_ft.sv
// Parity-protected fetch FIFO between the instruction bus interface and the aligner.
// Registered output (no fall-through); per-pop parity reporting with a saturating error counter.
module cv32e40p_fetch_fifo_ft #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_rdata_i,
  input  logic [DATA_W-1:0]          inject_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_rdata_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       parity_err_o,
  output logic [ERR_CNT_W-1:0]       err_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0]     par_q;

  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic push, pop;
  logic [DATA_W-1:0]    head_data;
  logic                 head_par;

  assign in_ready_o  = (cnt_q != CNT_FULL);
  assign out_valid_o = (cnt_q != '0);

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign head_data = mem_q[rptr_q];
  assign head_par  = par_q[rptr_q];

  assign out_rdata_o  = out_valid_o ? head_data : '0;
  assign parity_err_o = out_valid_o & ((^head_data) != head_par);
  assign cnt_o        = cnt_q;
  assign err_count_o  = err_cnt_q;

  // Parity covers the clean word; the injection mask corrupts only the stored copy.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wptr_q] <= in_rdata_i ^ inject_i;
      par_q[wptr_q] <= ^in_rdata_i;
    end
  end

  always_comb begin
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;

    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Flush leaves the error history intact; only pops of corrupted words count.
    if (pop && parity_err_o && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_fetch_fifo_ft.sv
// Bench for cv32e40p_fetch_fifo_ft: directed stimulus, scoreboard queue fed at the clock edge,
// monitor on the falling edge; a second instance with a 2-bit error counter shares the stimulus.
module tb_cv32e40p_fetch_fifo_ft;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_rdata = '0;
  logic [31:0] inject = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_o, out_valid_o, parity_err_o;
  logic [31:0] out_rdata_o;
  logic [2:0]  cnt_o;
  logic [7:0]  err_count_o;

  logic        in_ready2, out_valid2, parity_err2;
  logic [31:0] out_rdata2;
  logic [2:0]  cnt2;
  logic [1:0]  err_count2;

  cv32e40p_fetch_fifo_ft #(.DEPTH(DEPTH), .DATA_W(32), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_rdata_i(in_rdata), .inject_i(inject),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_rdata_o(out_rdata_o),
    .cnt_o(cnt_o), .parity_err_o(parity_err_o), .err_count_o(err_count_o)
  );

  cv32e40p_fetch_fifo_ft #(.DEPTH(DEPTH), .DATA_W(32), .ERR_CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready2), .in_rdata_i(in_rdata), .inject_i(inject),
    .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_rdata_o(out_rdata2),
    .cnt_o(cnt2), .parity_err_o(parity_err2), .err_count_o(err_count2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        pe;
  } exp_t;

  exp_t q[$];
  int   mcnt = 0;
  int   merr = 0;
  bit   mon_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Feeder: decides acceptance from its own occupancy model and queues the expected word.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      q.delete();
      mcnt = 0;
    end else begin
      bit acc, pop;
      pop = (mcnt != 0) && out_ready;
      acc = in_valid && (mcnt != DEPTH);
      if (acc) q.push_back(exp_t'{in_rdata ^ inject, ^inject});
      mcnt = mcnt + int'(acc) - int'(pop);
    end
  end

  // Monitor: checks status every cycle and pops the scoreboard whenever the DUT hands a word over.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid_o), 32'(mcnt != 0));
      chk("in_ready", 32'(in_ready_o), 32'(mcnt != DEPTH));
      chk("cnt", 32'(cnt_o), 32'(mcnt));
      chk("err_count", 32'(err_count_o), 32'(merr));
      chk("err_count_w2", 32'(err_count2), 32'((merr > 3) ? 3 : merr));
      if (!out_valid_o) begin
        chk("rdata_idle", out_rdata_o, 32'h0);
        chk("parity_idle", 32'(parity_err_o), 32'h0);
      end
      if (!rst_n) begin
        merr = 0;
      end else if (out_valid_o && out_ready && !flush) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL pop_empty: got a word %h expected none", out_rdata_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pop_data", out_rdata_o, e.d);
          chk("pop_parity", 32'(parity_err_o), 32'(e.pe));
          if (e.pe && merr < 255) merr++;
        end
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] d, input logic [31:0] inj,
                      input bit rdy, input bit fl);
    in_valid  = v;
    in_rdata  = d;
    inject    = inj;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // reset / idle
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_in_ready", 32'(in_ready_o), 32'h1);
    chk("rst_cnt", 32'(cnt_o), 32'h0);
    chk("rst_rdata", out_rdata_o, 32'h0);
    chk("rst_err", 32'(err_count_o), 32'h0);
    step(0, 32'h0, 32'h0, 0, 0);

    // three words then drain in order
    step(1, 32'h0000_0013, 32'h0, 0, 0);
    chk("lat1_valid", 32'(out_valid_o), 32'h1);
    step(1, 32'h00A0_0093, 32'h0, 0, 0);
    step(1, 32'h00B0_0113, 32'h0, 0, 0);
    chk("three_cnt", 32'(cnt_o), 32'd3);
    chk("seq0", out_rdata_o, 32'h0000_0013);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("seq1", out_rdata_o, 32'h00A0_0093);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("seq2", out_rdata_o, 32'h00B0_0113);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("seq_drained", 32'(out_valid_o), 32'h0);

    // fill to full, hold off the fifth word, then wrap
    for (int i = 0; i < 4; i++) step(1, 32'h0000_0100 + 32'(i), 32'h0, 0, 0);
    chk("full_in_ready", 32'(in_ready_o), 32'h0);
    chk("full_cnt", 32'(cnt_o), 32'd4);
    step(1, 32'h0000_0104, 32'h0, 0, 0);
    chk("held_cnt", 32'(cnt_o), 32'd4);
    chk("held_head", out_rdata_o, 32'h0000_0100);
    step(1, 32'h0000_0104, 32'h0, 1, 0);
    chk("full_pop_nopush_cnt", 32'(cnt_o), 32'd3);
    step(1, 32'h0000_0104, 32'h0, 0, 0);
    chk("fifth_accepted_cnt", 32'(cnt_o), 32'd4);
    step(0, 32'h0, 32'h0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 32'h0000_0200 + 32'(i), 32'h0, 1, 0);
    chk("pairs_cnt", 32'(cnt_o), 32'd3);
    chk("pairs_head", out_rdata_o, 32'h0000_0205);
    repeat (3) step(0, 32'h0, 32'h0, 1, 0);
    chk("wrap_drained", 32'(out_valid_o), 32'h0);

    // fault injection: odd flip detected, even flip not
    step(1, 32'h1234_5678, 32'h0000_0001, 0, 0);
    chk("inj1_data", out_rdata_o, 32'h1234_5679);
    chk("inj1_parity", 32'(parity_err_o), 32'h1);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("inj1_err", 32'(err_count_o), 32'd1);
    step(1, 32'h1234_5678, 32'h0000_0003, 0, 0);
    chk("inj3_data", out_rdata_o, 32'h1234_567B);
    chk("inj3_parity", 32'(parity_err_o), 32'h0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("inj3_err", 32'(err_count_o), 32'd1);

    // flush beats push and pop
    for (int i = 0; i < 3; i++) step(1, 32'h0000_0300 + 32'(i), 32'h0, 0, 0);
    step(1, 32'hBAD0_BAD0, 32'h0, 1, 1);
    chk("flush_cnt", 32'(cnt_o), 32'd0);
    chk("flush_valid", 32'(out_valid_o), 32'h0);
    chk("flush_err_kept", 32'(err_count_o), 32'd1);
    step(1, 32'hDEAD_BEEF, 32'h0, 0, 0);
    chk("post_flush_head", out_rdata_o, 32'hDEAD_BEEF);
    chk("post_flush_cnt", 32'(cnt_o), 32'd1);
    step(0, 32'h0, 32'h0, 1, 0);

    // five more corrupted pops: 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h0000_0400 + 32'(i), 32'h8000_0000, 0, 0);
      step(0, 32'h0, 32'h0, 1, 0);
    end
    chk("sat_err_w2", 32'(err_count2), 32'd3);
    chk("sat_err_w8", 32'(err_count_o), 32'd6);

    // reset with two entries held, overriding a concurrent handshake
    step(1, 32'h0000_0500, 32'h0, 0, 0);
    step(1, 32'h0000_0501, 32'h0, 0, 0);
    chk("pre_rst_cnt", 32'(cnt_o), 32'd2);
    rst_n = 1'b0;
    step(1, 32'h0000_0502, 32'h0, 1, 0);
    chk("mid_rst_cnt", 32'(cnt_o), 32'd0);
    chk("mid_rst_valid", 32'(out_valid_o), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready_o), 32'h1);
    chk("mid_rst_rdata", out_rdata_o, 32'h0);
    chk("mid_rst_parity", 32'(parity_err_o), 32'h0);
    chk("mid_rst_err", 32'(err_count_o), 32'd0);
    chk("mid_rst_err_w2", 32'(err_count2), 32'd0);
    rst_n = 1'b1;
    step(0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    chk("end_cnt", 32'(cnt_o), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
